instr_fetch_unit: RTL and testbench

- Upstream master of the instruction ROM. Owns the program counter, drives the ROM's chip-select/address strobe, waits out the ROM's ready-low/ready-high read sequence, and captures each returned word.
- Assembles each instruction from an opcode word followed by an operand word, then presents it to the decoder with a valid/ready handshake.
- Accepts a branch redirect from the execute stage.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/rom_rd_if.sv | 87 ++++++++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding, the opcode field width and the two word phases of an instruction.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_LO,
        WAIT_HI,
        HOLD
    } fetch_state_e;

    localparam int OPCODE_W = 6;

    localparam logic PHASE_OPC = 1'b0;
    localparam logic PHASE_OPR = 1'b1;

endpackage

// File: rtl/rom_rd_if.sv
// ROM read handshake: resync in IDLE, one-cycle cs strobe, ready-low/ready-high
// wait, and parking in HOLD. The FETCH_TIMEOUT_EN macro adds a sticky watchdog.
module rom_rd_if
    import fetch_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR     = '0,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              park,
    input  logic              resume,
    output logic              cs,
    output logic [ADDR_W-1:0] address,
    output fetch_state_e      state,
    output logic              word_valid,
    output logic [DATA_W-1:0] word,
    output logic              timeout,
    output logic              fetch_err
);

    fetch_state_e state_next;
    logic         ready_seen;

    assign word_valid = (state == WAIT_HI) && mem_ready;
    assign word       = mem_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_ready && ready_seen) state_next = REQ;
            REQ:     state_next = WAIT_LO;
            WAIT_LO: if (!mem_ready) state_next = WAIT_HI;
            WAIT_HI: if (mem_ready) state_next = park ? HOLD : REQ;
            HOLD:    if (resume) state_next = REQ;
            default: state_next = IDLE;
        endcase
        if (timeout) state_next = IDLE;
    end

    // The ROM has no reset, so IDLE only trusts ready after two consecutive high samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cs         <= 1'b0;
            address    <= RESET_ADDR;
            ready_seen <= 1'b0;
        end else begin
            state      <= state_next;
            cs         <= (state_next == REQ);
            ready_seen <= (state == IDLE) && mem_ready;
            if (state_next == REQ) address <= req_addr;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);

    logic [3:0] tmo_cnt;

    assign timeout = ((state == WAIT_LO) || ((state == WAIT_HI) && !mem_ready))
                     && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= 4'd0;
            fetch_err <= 1'b0;
        end else begin
            if (state == REQ) tmo_cnt <= 4'd0;
            else if ((state == WAIT_LO) || (state == WAIT_HI)) tmo_cnt <= tmo_cnt + 4'd1;
            if (timeout) fetch_err <= 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, opcode/operand assembly, decoder
// handshake and branch redirect. FETCH_TIMEOUT_EN enables the ROM watchdog.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 16,
    parameter logic [ADDR_W-1:0] RESET_PC       = 16'h0000,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                cs,
    output logic [ADDR_W-1:0]   address,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                ins_valid,
    input  logic                ins_ready,
    output logic [OPCODE_W-1:0] ins_opcode,
    output logic [DATA_W-1:0]   ins_operand,
    output logic [ADDR_W-1:0]   ins_pc,
    output logic                fetch_err
);

    fetch_state_e          state;
    logic                  word_valid;
    logic [DATA_W-1:0]     word;
    logic                  timeout;

    logic [ADDR_W-1:0]     pc;
    logic [ADDR_W-1:0]     pc_next;
    logic                  phase;
    logic                  phase_next;
    logic                  discard;
    logic                  discard_next;
    logic [OPCODE_W-1:0]   opc_q;
    logic [ADDR_W-1:0]     opc_pc_q;

    logic                  keep;
    logic                  busy;
    logic                  park;
    logic                  resume;

    assign keep   = word_valid && !discard && !redirect;
    assign busy   = (state == REQ) || (state == WAIT_LO) || (state == WAIT_HI);
    assign park   = (phase == PHASE_OPR) && !discard && !redirect;
    assign resume = ins_ready || redirect;

    rom_rd_if #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .RESET_ADDR     (RESET_PC),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rom_rd_if (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .req_addr   (pc_next),
        .park       (park),
        .resume     (resume),
        .cs         (cs),
        .address    (address),
        .state      (state),
        .word_valid (word_valid),
        .word       (word),
        .timeout    (timeout),
        .fetch_err  (fetch_err)
    );

    // A redirect during an issued ROM read cannot abort it, so the word that
    // eventually comes back is marked for dropping instead.
    always_comb begin
        pc_next      = pc;
        phase_next   = phase;
        discard_next = discard;
        if (redirect) begin
            pc_next    = redirect_pc;
            phase_next = PHASE_OPC;
        end else if (keep) begin
            pc_next    = pc + 1'b1;
            phase_next = ~phase;
        end
        if (word_valid || timeout) discard_next = 1'b0;
        else if (redirect && busy) discard_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            phase       <= PHASE_OPC;
            discard     <= 1'b0;
            opc_q       <= '0;
            opc_pc_q    <= '0;
            ins_valid   <= 1'b0;
            ins_opcode  <= '0;
            ins_operand <= '0;
            ins_pc      <= '0;
        end else begin
            pc      <= pc_next;
            phase   <= phase_next;
            discard <= discard_next;
            if (keep && (phase == PHASE_OPC)) begin
                opc_q    <= word[OPCODE_W-1:0];
                opc_pc_q <= pc;
            end
            if (keep && (phase == PHASE_OPR)) begin
                ins_valid   <= 1'b1;
                ins_opcode  <= opc_q;
                ins_operand <= word;
                ins_pc      <= opc_pc_q;
            end else if (redirect || (ins_valid && ins_ready)) begin
                ins_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural ROM (ready-low/ready-high
// read, data driven for one cycle). Timeout checks follow FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

    typedef struct {
        logic [15:0] pc;
        logic [5:0]  opc;
        logic [15:0] opr;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs;
    logic [15:0] address;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [5:0]  ins_opcode;
    logic [15:0] ins_operand;
    logic [15:0] ins_pc;
    logic        fetch_err;

    logic        rom_ready = 1'b1;
    logic [15:0] rom_data = 16'h0000;
    logic [15:0] rom_addr = 16'h0000;
    int          rom_phase = 0;
    logic        rom_stall = 1'b0;

    logic [15:0] cs_addrs[$];
    logic        cs_prev = 1'b0;
    int          cs_wide = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    vec_t        vecs[3];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .address     (address),
        .mem_ready   (rom_ready),
        .mem_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_opcode  (ins_opcode),
        .ins_operand (ins_operand),
        .ins_pc      (ins_pc),
        .fetch_err   (fetch_err)
    );

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h0028;
        if (a == 16'h0001) return 16'd30;
        return a ^ 16'h5A5A;
    endfunction

    // ROM: sees cs, drops ready, then raises ready with data valid for one cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (rom_phase)
            0: if (cs) begin
                rom_ready <= 1'b0;
                rom_addr  <= address;
                rom_phase <= 1;
            end
            1: if (!rom_stall) begin
                rom_ready <= 1'b1;
                rom_data  <= rom_word(rom_addr);
                rom_phase <= 2;
            end
            default: begin
                rom_data  <= 16'hzzzz;
                rom_phase <= 0;
            end
        endcase
    end

    always @(posedge clk) begin
        if (cs) cs_addrs.push_back(address);
        if (cs && cs_prev) cs_wide <= cs_wide + 1;
        cs_prev <= cs;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int idx);
        if (idx >= 0 && idx < cs_addrs.size()) return 32'(cs_addrs[idx]);
        return 32'hDEADBEEF;
    endfunction

    task automatic waitValid();
        for (int i = 0; i < 80 && ins_valid !== 1'b1; i++) @(negedge clk);
        checkOutput("ins_valid arrives", 32'(ins_valid), 32'd1);
    endtask

    task automatic checkInstr(input vec_t v);
        string tag;
        tag = $sformatf("pc%04h", v.pc);
        waitValid();
        checkOutput({tag, " ins_pc"}, 32'(ins_pc), 32'(v.pc));
        checkOutput({tag, " ins_opcode"}, 32'(ins_opcode), 32'(v.opc));
        checkOutput({tag, " ins_operand"}, 32'(ins_operand), 32'(v.opr));
        checkOutput({tag, " opcode req addr"}, q_at(0), 32'(v.pc));
        checkOutput({tag, " operand req addr"}, q_at(cs_addrs.size() - 1), 32'(16'(v.pc + 16'd1)));
    endtask

    task automatic handshake();
        ins_ready = 1'b1;
        cs_addrs.delete();
        @(negedge clk);
        ins_ready = 1'b0;
        checkOutput("ins_valid drops after handshake", 32'(ins_valid), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        checkInstr(v);
        repeat (v.hold) @(negedge clk);
        handshake();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n;
        int   t0;
        int   bad;
        vec_t v;
        logic [5:0]  s_opc;
        logic [15:0] s_opr;
        logic [15:0] s_pc;

        vecs[0] = '{16'h0002, 6'h18, 16'h5A59, 0};
        vecs[1] = '{16'h0004, 6'h1E, 16'h5A5F, 0};
        vecs[2] = '{16'h0006, 6'h1C, 16'h5A5D, 2};

        repeat (3) @(negedge clk);
        checkOutput("reset cs", 32'(cs), 32'd0);
        checkOutput("reset address", 32'(address), 32'h0000);
        checkOutput("reset ins_valid", 32'(ins_valid), 32'd0);
        checkOutput("reset ins_opcode", 32'(ins_opcode), 32'd0);
        checkOutput("reset ins_operand", 32'(ins_operand), 32'd0);
        checkOutput("reset ins_pc", 32'(ins_pc), 32'd0);
        checkOutput("reset fetch_err", 32'(fetch_err), 32'd0);
        cs_addrs.delete();
        rst_n = 1'b1;

        $display("[TB] first instruction after reset");
        n = 0;
        while (cs !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first REQ issued", 32'(cs), 32'd1);
        t0 = cyc;
        v = '{16'h0000, 6'b101000, 16'd30, 0};
        checkInstr(v);
        checkOutput("valid latency from first REQ", 32'(cyc - t0), 32'd6);

        $display("[TB] decoder stall");
        s_opc = ins_opcode;
        s_opr = ins_operand;
        s_pc  = ins_pc;
        cs_addrs.delete();
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (ins_valid !== 1'b1 || ins_opcode !== s_opc || ins_operand !== s_opr ||
                ins_pc !== s_pc || cs !== 1'b0) bad++;
        end
        checkOutput("hold outputs stable", 32'(bad), 32'd0);
        checkOutput("no cs during hold", 32'(cs_addrs.size()), 32'd0);
        handshake();

        $display("[TB] sequential vectors");
        for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

        $display("[TB] redirect during operand WAIT_LO");
        n = 0;
        while (!(cs === 1'b1 && address === 16'h0009) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("operand REQ address", 32'(address), 32'h0009);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 16'h0014;
        cs_addrs.delete();
        @(negedge clk);
        redirect = 1'b0;
        v = '{16'h0014, 6'h0E, 16'h5A4F, 0};
        checkInstr(v);

        $display("[TB] redirect with same-cycle ins_ready");
        ins_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        cs_addrs.delete();
        @(negedge clk);
        ins_ready = 1'b0;
        redirect  = 1'b0;
        checkOutput("ins_valid cleared by redirect", 32'(ins_valid), 32'd0);
        v = '{16'h0040, 6'h1A, 16'h5A1B, 0};
        checkInstr(v);

        $display("[TB] pc wrap");
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        cs_addrs.delete();
        @(negedge clk);
        redirect = 1'b0;
        v = '{16'hFFFF, 6'h25, 16'h0028, 0};
        checkInstr(v);
        handshake();
        v = '{16'h0001, 6'h1E, 16'h5A58, 0};
        checkInstr(v);

        $display("[TB] stalled ROM");
        ins_ready = 1'b1;
        rom_stall = 1'b1;
        cs_addrs.delete();
        @(negedge clk);
        ins_ready = 1'b0;
        checkOutput("stall REQ cs", 32'(cs), 32'd1);
        checkOutput("stall REQ address", 32'(address), 32'h0003);
`ifdef FETCH_TIMEOUT_EN
        n = 0;
        while (fetch_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fetch_err raised", 32'(fetch_err), 32'd1);
        checkOutput("timeout latency", 32'(n), 32'd16);
        repeat (3) @(negedge clk);
        checkOutput("no cs while resyncing", 32'(cs_addrs.size()), 32'd1);
        rom_stall = 1'b0;
        v = '{16'h0003, 6'h19, 16'h5A5E, 0};
        checkInstr(v);
        checkOutput("retry address", q_at(1), 32'h0003);
        checkOutput("fetch_err sticky", 32'(fetch_err), 32'd1);
`else
        repeat (20) @(negedge clk);
        checkOutput("fetch_err tied low", 32'(fetch_err), 32'd0);
        checkOutput("no extra cs while waiting", 32'(cs_addrs.size()), 32'd1);
        checkOutput("no valid while waiting", 32'(ins_valid), 32'd0);
        rom_stall = 1'b0;
        v = '{16'h0003, 6'h19, 16'h5A5E, 0};
        checkInstr(v);
`endif
        checkOutput("cs single-cycle pulses", 32'(cs_wide), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
